// File: rtl/bn_rr_arbiter_8_if.sv
// Request/grant bundle between eight requesters and the
// round-robin arbiter feeding a one-hot 8-to-1 selector.
interface bn_rr_arbiter_8_if;
   logic [7:0] req;
   logic       done;
   logic [7:0] sel;
   logic       sel_valid;
   logic [2:0] grant_id;
   logic       timeout;

   modport master (
      output req,
      output done,
      input  sel,
      input  sel_valid,
      input  grant_id,
      input  timeout
   );

   modport slave (
      input  req,
      input  done,
      output sel,
      output sel_valid,
      output grant_id,
      output timeout
   );
endinterface

// File: rtl/bn_rr_arbiter_8.sv
// Round-robin arbiter with bounded hold time driving the
// one-hot select of a downstream 8-to-1 selector.
module bn_rr_arbiter_8 #(
   parameter int MAX_HOLD = 16,
   parameter int CNT_W    = 5
) (
   input logic            clk,
   input logic            rst_n,
   bn_rr_arbiter_8_if.slave bus
);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t           state_q, state_d;
   logic [2:0]       ptr_q, ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [7:0]       sel_q, sel_d;
   logic [2:0]       gid_q, gid_d;
   logic             valid_q, valid_d;
   logic             to_q, to_d;

   logic [2:0]       pick_id;
   logic [2:0]       idx;
   logic             found;
   logic             rel_done;
   logic             rel_drop;
   logic             rel_max;

   // first requester at or above ptr, wrapping past 7
   always_comb begin
      found   = 1'b0;
      pick_id = ptr_q;
      idx     = ptr_q;
      for (int i = 0; i < 8; i++) begin
         idx = ptr_q + 3'(i);
         if (!found && bus.req[idx]) begin
            found   = 1'b1;
            pick_id = idx;
         end
      end
   end

   assign rel_done = bus.done;
   assign rel_drop = !bus.req[gid_q];
   assign rel_max  = (cnt_q == CNT_W'(MAX_HOLD - 1));

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      sel_d   = sel_q;
      gid_d   = gid_q;
      valid_d = valid_q;
      to_d    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (found) begin
               state_d = GRANT;
               sel_d   = 8'b1 << pick_id;
               gid_d   = pick_id;
               valid_d = 1'b1;
               cnt_d   = '0;
            end
         end
         GRANT: begin
            cnt_d = cnt_q + 1'b1;
            if (rel_done || rel_drop || rel_max) begin
               state_d = IDLE;
               sel_d   = 8'b0;
               valid_d = 1'b0;
               cnt_d   = '0;
               ptr_d   = gid_q + 3'd1;
               to_d    = rel_max && !rel_done && !rel_drop;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         cnt_q   <= '0;
         sel_q   <= '0;
         gid_q   <= '0;
         valid_q <= 1'b0;
         to_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         sel_q   <= sel_d;
         gid_q   <= gid_d;
         valid_q <= valid_d;
         to_q    <= to_d;
      end
   end

   assign bus.sel       = sel_q;
   assign bus.sel_valid = valid_q;
   assign bus.grant_id  = gid_q;
   assign bus.timeout   = to_q;

endmodule

// File: tb/tb_bn_rr_arbiter_8.sv
// Directed vector bench for bn_rr_arbiter_8 with a
// behavioural 8-to-1 selector on the grant output.
module tb_bn_rr_arbiter_8;

   logic clk;
   logic rst_n;

   bn_rr_arbiter_8_if bus ();

   bn_rr_arbiter_8 #(
      .MAX_HOLD (16),
      .CNT_W    (5)
   ) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic [7:0] req;
      logic       done;
      logic [7:0] esel;
      logic [2:0] egid;
      logic       ev;
      logic       eto;
   } vec_t;

   vec_t vq[$];
   int   tot;
   int   bad;

   logic [7:0] dat [8];
   logic [7:0] y;

   // downstream selector: y = d[i] for the one-hot sel bit
   always_comb begin
      y = 8'h00;
      for (int i = 0; i < 8; i++)
         if (bus.sel[i]) y = y | dat[i];
   end

   task automatic cmp(input string nm,
                      input logic [7:0] got,
                      input logic [7:0] exp);
      tot++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h", nm, got, exp);
      end
   endtask

   task automatic check(input string nm,
                        input logic [7:0] esel,
                        input logic [2:0] egid,
                        input logic ev,
                        input logic eto);
      cmp({nm, ".sel"}, bus.sel, esel);
      cmp({nm, ".gid"}, 8'(bus.grant_id), 8'(egid));
      cmp({nm, ".valid"}, 8'(bus.sel_valid), 8'(ev));
      cmp({nm, ".to"}, 8'(bus.timeout), 8'(eto));
      if (bus.sel_valid)
         cmp({nm, ".y"}, y, dat[egid]);
   endtask

   task automatic step(input logic [7:0] r, input logic d);
      bus.req  = r;
      bus.done = d;
      @(posedge clk);
      #1;
      bus.done = 1'b0;
   endtask

   task automatic do_rst();
      bus.req  = 8'h00;
      bus.done = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check("rst", 8'h00, 3'd0, 1'b0, 1'b0);
      rst_n = 1'b1;
   endtask

   task automatic add(input logic rst, input logic [7:0] r,
                      input logic d, input logic [7:0] es,
                      input logic [2:0] eg, input logic ev,
                      input logic et);
      vec_t v;
      v.rst  = rst;
      v.req  = r;
      v.done = d;
      v.esel = es;
      v.egid = eg;
      v.ev   = ev;
      v.eto  = et;
      vq.push_back(v);
   endtask

   initial begin
      tot      = 0;
      bad      = 0;
      rst_n    = 1'b0;
      bus.req  = 8'h00;
      bus.done = 1'b0;
      for (int i = 0; i < 8; i++)
         dat[i] = 8'h30 + 8'(i * 17);

      // single requester, done, one idle gap, re-grant
      add(1, 8'h00, 0, 8'h00, 0, 0, 0);
      add(0, 8'h08, 0, 8'h08, 3, 1, 0);
      add(0, 8'h08, 1, 8'h00, 3, 0, 0);
      add(0, 8'h08, 0, 8'h08, 3, 1, 0);
      add(0, 8'h00, 0, 8'h00, 3, 0, 0);
      // full rotation from ptr 0
      add(1, 8'h00, 0, 8'h00, 0, 0, 0);
      for (int k = 0; k < 9; k++) begin
         add(0, 8'hFF, 0, 8'b1 << (k % 8), 3'(k % 8), 1, 0);
         add(0, 8'hFF, 1, 8'h00, 3'(k % 8), 0, 0);
      end
      // wrap: grant 6 leaves ptr at 7
      add(0, 8'h40, 0, 8'h40, 6, 1, 0);
      add(0, 8'h40, 1, 8'h00, 6, 0, 0);
      add(0, 8'h41, 0, 8'h01, 0, 1, 0);
      add(0, 8'h41, 1, 8'h00, 0, 0, 0);
      add(0, 8'h41, 0, 8'h40, 6, 1, 0);
      add(0, 8'h41, 1, 8'h00, 6, 0, 0);
      // other bits ignored mid-grant, then own req drops
      add(0, 8'h04, 0, 8'h04, 2, 1, 0);
      add(0, 8'h0F, 0, 8'h04, 2, 1, 0);
      add(0, 8'hFB, 0, 8'h00, 2, 0, 0);
      add(0, 8'h00, 1, 8'h00, 2, 0, 0);
      add(0, 8'hFF, 0, 8'h08, 3, 1, 0);
      add(0, 8'hFF, 1, 8'h00, 3, 0, 0);

      foreach (vq[i]) begin
         if (vq[i].rst) do_rst();
         else begin
            step(vq[i].req, vq[i].done);
            check($sformatf("vec%0d", i), vq[i].esel,
                  vq[i].egid, vq[i].ev, vq[i].eto);
         end
      end

      // async reset mid-grant, then restart from requester 0
      do_rst();
      step(8'h04, 0);
      check("pre_rst", 8'h04, 3'd2, 1'b1, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst", 8'h00, 3'd0, 1'b0, 1'b0);
      #1;
      rst_n = 1'b1;
      step(8'h84, 0);
      check("post_rst", 8'h04, 3'd2, 1'b1, 1'b0);

      // timeout after 16 held cycles
      do_rst();
      step(8'h20, 0);
      check("to_grant", 8'h20, 3'd5, 1'b1, 1'b0);
      for (int j = 1; j <= 16; j++) begin
         step(8'h20, 0);
         if (j < 16)
            check($sformatf("to_hold%0d", j),
                  8'h20, 3'd5, 1'b1, 1'b0);
         else
            check("to_fire", 8'h00, 3'd5, 1'b0, 1'b1);
      end
      step(8'h00, 0);
      check("to_pulse", 8'h00, 3'd5, 1'b0, 1'b0);
      step(8'h21, 0);
      check("to_ptr", 8'h01, 3'd0, 1'b1, 1'b0);
      step(8'h21, 1);
      check("to_rel", 8'h00, 3'd0, 1'b0, 1'b0);

      // done coinciding with last hold cycle suppresses timeout
      step(8'h20, 0);
      check("dc_grant", 8'h20, 3'd5, 1'b1, 1'b0);
      for (int j = 1; j <= 16; j++) begin
         step(8'h20, logic'(j == 16));
         if (j == 16)
            check("dc_rel", 8'h00, 3'd5, 1'b0, 1'b0);
      end
      step(8'h00, 0);
      check("dc_idle", 8'h00, 3'd5, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", tot, bad);
      $finish;
   end

endmodule
